// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and the ID-stage hazard unit.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} rf_state_e;

  // Index of the write port whose data a matching read takes; higher port is the newer value.
  function automatic logic bypass_sel(input logic [1:0] hit);
    return hit[1];
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bundle between the ID/WB stages and regfile_mp.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd;
  logic [NUM_WR-1:0]             we;
  logic [NUM_WR-1:0][ADDR_W-1:0] wa;
  logic [NUM_WR-1:0][DATA_W-1:0] wd;
  logic                          ready;
  logic                          sb_set;
  logic [ADDR_W-1:0]             sb_addr;
  logic [NUM_RD-1:0]             rd_busy;

  modport master (output ra, we, wa, wd, sb_set, sb_addr, input rd, ready, rd_busy);
  modport slave  (input ra, we, wa, wd, sb_set, sb_addr, output rd, ready, rd_busy);
endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sweep: zeroes one entry per cycle, then holds READY until the next reset.
module regfile_clear_fsm import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we_o  = 1'b0;
    ready_o   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_o  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = READY;
      end
      READY: ready_o = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr_o = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with clear sweep, zero register and write-to-read bypass.
// Optional pending-producer scoreboard under REGFILE_SCOREBOARD_EN.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rstn,
  regfile_mp_if.slave  rf_if
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_WR-1:0] wr_en;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .rstn       (rstn),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign rf_if.ready = ready;

  // Port writes only count once the sweep is done; entry 0 writes vanish with ZERO_REG.
  always_comb begin
    wr_en = '0;
    for (int j = 0; j < NUM_WR; j++)
      wr_en[j] = ready && rf_if.we[j] && !(ZERO_REG != 0 && rf_if.wa[j] == '0);
  end

  // Later ports assign last, so the highest index wins on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j]) mem_q[rf_if.wa[j]] <= rf_if.wd[j];
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;

  // Clear first, then set, so a new producer issued on a retiring address stays pending.
  always_comb begin
    pend_d = pend_q;
    if (ready) begin
      for (int j = 0; j < NUM_WR; j++)
        if (rf_if.we[j]) pend_d[rf_if.wa[j]] = 1'b0;
      if (rf_if.sb_set) pend_d[rf_if.sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) pend_q <= '0;
    else       pend_q <= pend_d;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{rf_if.sb_set, rf_if.sb_addr};
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [1:0]        hit;
    logic              zero_rd;
    logic [DATA_W-1:0] bp_data;
    logic [DATA_W-1:0] rd_v;

    always_comb begin
      hit = '0;
      for (int j = 0; j < NUM_WR; j++)
        hit[j] = wr_en[j] && (rf_if.wa[j] == rf_if.ra[i]);
      bp_data = '0;
      for (int j = 0; j < NUM_WR; j++)
        if (j == int'(bypass_sel(hit))) bp_data = rf_if.wd[j];
      zero_rd = (ZERO_REG != 0) && (rf_if.ra[i] == '0);
      if (!ready || zero_rd)           rd_v = '0;
      else if (BYPASS != 0 && |hit)    rd_v = bp_data;
      else                             rd_v = mem_q[rf_if.ra[i]];
    end

    assign rf_if.rd[i] = rd_v;

`ifdef REGFILE_SCOREBOARD_EN
    assign rf_if.rd_busy[i] = ready && !zero_rd && pend_q[rf_if.ra[i]] &&
                              !(BYPASS != 0 && |hit);
`else
    assign rf_if.rd_busy[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp (2 read, 2 write ports) against an array/counter reference model.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2, DEPTH = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(1)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rf_if (bus)
  );

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_pend [DEPTH];
  int            clr_left = DEPTH;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_ready();
    return clr_left == 0;
  endfunction

  // Newest write this cycle to ra[i], -1 if none (addr 0 never matches).
  function automatic int ref_hit(int i);
    int h = -1;
    for (int j = 0; j < NW; j++)
      if (bus.we[j] && bus.wa[j] == bus.ra[i] && bus.ra[i] != 0) h = j;
    return h;
  endfunction

  function automatic logic [DW-1:0] ref_rd(int i);
    int h;
    if (!ref_ready() || bus.ra[i] == 0) return '0;
    h = ref_hit(i);
    if (h >= 0) return bus.wd[h];
    return ref_mem[bus.ra[i]];
  endfunction

  function automatic logic ref_busy(int i);
`ifdef REGFILE_SCOREBOARD_EN
    return ref_ready() && bus.ra[i] != 0 && ref_pend[bus.ra[i]] && ref_hit(i) < 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      clr_left = DEPTH;
      for (int a = 0; a < DEPTH; a++) ref_pend[a] = 1'b0;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.we[j] && bus.wa[j] != 0) ref_mem[bus.wa[j]] = bus.wd[j];
        if (bus.we[j]) ref_pend[bus.wa[j]] = 1'b0;
      end
      if (bus.sb_set) ref_pend[bus.sb_addr] = 1'b1;
    end
  endtask

  // Inputs are set at the falling edge; compare, clock, advance the model.
  task automatic step();
    #1;
    check("ready", bus.ready, ref_ready());
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rd%0d", i), bus.rd[i], ref_rd(i));
      check($sformatf("busy%0d", i), bus.rd_busy[i], ref_busy(i));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] a0);
    bus.we = '0; bus.sb_set = 1'b0;
    bus.ra[0] = a0; bus.ra[1] = AW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic rand_in(input int amax);
    for (int i = 0; i < NR; i++) bus.ra[i] = AW'($urandom_range(0, amax));
    for (int j = 0; j < NW; j++) begin
      bus.we[j] = 1'($urandom_range(0, 1));
      bus.wa[j] = AW'($urandom_range(0, amax));
      bus.wd[j] = DW'($urandom);
    end
    bus.sb_set  = 1'($urandom_range(0, 1));
    bus.sb_addr = AW'($urandom_range(0, amax));
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin ref_mem[a] = '0; ref_pend[a] = 1'b0; end
    bus.wa = '0; bus.wd = '0; bus.sb_addr = '0;
    idle('0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    step();

    // full sweep with write/scoreboard noise that must be ignored
    rstn = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin rand_in(DEPTH - 1); step(); end
    idle('0);
    #1 check("ready_after_sweep", bus.ready, 1'b1);

    // reset mid-sweep at clr_idx=10
    rstn = 1'b0; step();
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin rand_in(DEPTH - 1); step(); end
    rstn = 1'b0; idle('0); step();
    rstn = 1'b1;
    for (int c = 0; c < DEPTH - 1; c++) begin rand_in(DEPTH - 1); step(); end
    idle('0);
    #1 check("restart_not_ready", bus.ready, 1'b0);
    step();
    #1 check("restart_ready", bus.ready, 1'b1);

    // bypass then stored
    idle(5'd5);
    bus.we = 2'b01; bus.wa[0] = 5'd5; bus.wd[0] = 32'hDEADBEEF;
    #1 check("bypass", bus.rd[0], 32'hDEADBEEF);
    step();
    idle(5'd5);
    #1 check("stored", bus.rd[0], 32'hDEADBEEF);
    step();

    // same-address double write: port 1 wins
    idle(5'd7);
    bus.we = 2'b11; bus.wa[0] = 5'd7; bus.wa[1] = 5'd7; bus.wd[0] = 32'd1; bus.wd[1] = 32'd2;
    #1 check("dual_bypass", bus.rd[0], 32'd2);
    step();
    idle(5'd7);
    #1 check("dual_stored", bus.rd[0], 32'd2);
    step();

    // zero register
    idle(5'd0);
    bus.we = 2'b01; bus.wa[0] = 5'd0; bus.wd[0] = 32'h55;
    #1 check("zero_bypass", bus.rd[0], 32'd0);
    step();
    idle(5'd0);
    #1 check("zero_stored", bus.rd[0], 32'd0);
    step();

`ifdef REGFILE_SCOREBOARD_EN
    idle(5'd9);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    step();
    idle(5'd9);
    #1 check("sb_busy", bus.rd_busy[0], 1'b1);
    bus.we = 2'b01; bus.wa[0] = 5'd9; bus.wd[0] = 32'h99;
    #1 check("sb_bypass_clear", bus.rd_busy[0], 1'b0);
    step();
    idle(5'd9);
    #1 check("sb_cleared", bus.rd_busy[0], 1'b0);
    step();
`endif

    // random traffic, narrow address range for frequent hits, rare resets
    for (int c = 0; c < 600; c++) begin
      rand_in(($urandom_range(0, 1) != 0) ? 7 : DEPTH - 1);
      rstn = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
